aes_round_ctrl: RTL
===================

# aes_round_ctrl

Round sequencer for the AES datapath: accepts an encrypt/decrypt request, then drives the key-schedule and cipher datapaths cycle by cycle with init/step strobes and the round index. For decryption it first runs the forward key expansion to reach the last round key, then runs inverse expansion alongside the inverse cipher. It sits between the SPI front end (start/dir/done handshake) and the expand/cipher datapath blocks. It holds no data, only sequencing state.

## Interface
- K, 128, key length in bits; legal values 128/192/256 (Nr = 10/12/14); any other value is an elaboration error
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; level, sampled only in IDLE
- dir  input  1  0 = encrypt, 1 = decrypt; sampled with start
- abort  input  1  only present with AES_CTRL_ABORT_EN
- busy  output  1  high in any state except IDLE
- done  output  1  result valid on datapath output
- ks_init  output  1  key schedule: load input key as round key 0
- ks_step  output  1  key schedule: advance one round key
- ks_inv  output  1  key schedule steps run inverse (decrypt, post-KEXP)
- ci_load  output  1  cipher: state <= text XOR current round key
- ci_step  output  1  cipher: perform one round
- ci_last  output  1  qualifies ci_step as final round (no MixColumns)
- ci_inv  output  1  cipher direction, latched dir
- round  output  4  current round index

## Operation
- States: IDLE, KEXP, LOAD, ROUND, DONE.
- IDLE: if start=1, latch dir into ci_inv, then go to KEXP if dir=1, otherwise to LOAD. round=0.
- KEXP (decrypt only): lasts Nr+1 cycles. Cycle 0 asserts ks_init. Cycles 1..Nr assert ks_step with ks_inv=0. round counts 0..Nr. Then go to LOAD.
- LOAD: lasts 1 cycle. Asserts ci_load. round = 0 for encrypt, Nr for decrypt. In encrypt, also asserts ks_init on the same cycle.
- ROUND: lasts Nr cycles. Each cycle asserts ks_step and ci_step.
  - Encrypt: round counts 1..Nr; ci_last=1 when round=Nr.
  - Decrypt: round counts Nr-1 down to 0; ks_inv=1; ci_last=1 when round=0.
- DONE: done=1, all strobes low. Stay in DONE while start=1; go to IDLE on the cycle after start=0. done is high for at least 1 cycle.
- dir and start changes outside IDLE are ignored.
- round wraps never. Counter width is 4 bits; max value 14.
- A new request requires start to be low for at least 1 cycle in IDLE after DONE (no back-to-back on a held start).

## Timing
- Reset: state IDLE. busy, done, all strobes, ci_inv, ks_inv = 0; round = 0.
- Reset asserted in any state returns to IDLE on the next edge, with outputs at reset values on that edge. No done is produced for the aborted operation.
- All outputs are registered-state decodes; no combinational path from start/dir to outputs.
- Edge 0 samples start. Encrypt: LOAD in cycle 1, ROUND in cycles 2..Nr+1, done first high in cycle Nr+2 (12/14/16).
- Decrypt: KEXP in cycles 1..Nr+1, LOAD in cycle Nr+2, ROUND in cycles Nr+3..2Nr+2, done in cycle 2Nr+3 (23/27/31).
- busy is high from cycle 1 through the last DONE cycle.

## Configuration
- AES_CTRL_ABORT_EN
  - Defined: abort port exists. abort=1 in any non-IDLE state forces IDLE on the next edge, with all strobes low and no done. abort in IDLE is ignored. When reset and abort are both high, reset takes priority (same result).
  - Undefined: no abort port; an operation always runs to DONE.

## Test plan
- K=128, encrypt: start=1 at edge 0 and held → ci_load+ks_init in cycle 1; ci_step in cycles 2..11 with round 1..10; ci_last only in cycle 11; done=1 from cycle 12 until start drops, then IDLE next cycle.
- K=128, decrypt: KEXP ks_init in cycle 1, ks_step in cycles 2..11 with ks_inv=0; ci_load in cycle 12 with round=10; rounds 9..0 with ks_inv=1; ci_last in cycle 22; done in cycle 23.
- K=256, decrypt → done in cycle 31; K=192, encrypt → done in cycle 14; round never exceeds Nr.
- Reset pulsed in the middle of ROUND (cycle 6) → cycle 7 shows IDLE, all outputs 0; a new start afterward gives normal latency.
- Start held high after done, and dir toggled during the operation → exactly one operation runs, with the direction sampled at edge 0; a second operation requires start low for 1 cycle first.
- AES_CTRL_ABORT_EN defined: abort in cycle 5 of a decrypt → IDLE next cycle, done never asserted; abort in IDLE → no effect.

Source files
------------

// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if: start/dir request and busy/done status between the SPI front end and the round sequencer
//   start  level request from the front end
//   dir    0 = encrypt, 1 = decrypt, qualified by start
//   busy   sequencer is running an operation
//   done   result valid on the datapath output
//   master modport: front end; slave modport: sequencer
interface aes_round_ctrl_if;
    logic start;
    logic dir;
    logic busy;
    logic done;
    modport master (output start, dir, input busy, done);
    modport slave (input start, dir, output busy, done);
endinterface

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: AES round sequencer driving key-schedule and cipher strobes cycle by cycle
//   clk, reset      clock and synchronous active-high reset
//   bus (slave)     start/dir request, busy/done status
//   abort           forces IDLE from any busy state; present only with AES_CTRL_ABORT_EN
//   ks_init/ks_step/ks_inv   key-schedule load, advance, inverse direction
//   ci_load/ci_step/ci_last  cipher initial key add, round, final round qualifier
//   ci_inv          latched direction
//   round           current round index
module aes_round_ctrl #(
    parameter int K = 128
) (
    input  logic                   clk,
    input  logic                   reset,
    aes_round_ctrl_if.slave        bus,
`ifdef AES_CTRL_ABORT_EN
    input  logic                   abort,
`endif
    output logic                   ks_init,
    output logic                   ks_step,
    output logic                   ks_inv,
    output logic                   ci_load,
    output logic                   ci_step,
    output logic                   ci_last,
    output logic                   ci_inv,
    output logic [3:0]             round
);
    localparam logic [3:0] NR = (K == 256) ? 4'd14 : (K == 192) ? 4'd12 : 4'd10;

    generate
        if (K != 128 && K != 192 && K != 256) begin : g_bad_k
            $error("aes_round_ctrl: K must be 128, 192 or 256");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, KEXP, LOAD, ROUND, DONE} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       inv_q, inv_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            inv_q   <= inv_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        inv_d    = inv_q;
        bus.busy = state_q != IDLE;
        bus.done = 1'b0;
        ks_init  = 1'b0;
        ks_step  = 1'b0;
        ks_inv   = 1'b0;
        ci_load  = 1'b0;
        ci_step  = 1'b0;
        ci_last  = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                inv_d   = bus.dir;
                cnt_d   = '0;
                state_d = bus.dir ? KEXP : LOAD;
            end
            // forward expansion to the last round key; cnt is left at NR for the decrypt LOAD
            KEXP: begin
                ks_init = cnt_q == 4'd0;
                ks_step = cnt_q != 4'd0;
                if (cnt_q == NR) state_d = LOAD;
                else cnt_d = cnt_q + 4'd1;
            end
            // encrypt loads round key 0 into the schedule alongside the initial key add
            LOAD: begin
                ci_load = 1'b1;
                ks_init = !inv_q;
                state_d = ROUND;
                cnt_d   = inv_q ? NR - 4'd1 : 4'd1;
            end
            ROUND: begin
                ks_step = 1'b1;
                ci_step = 1'b1;
                ks_inv  = inv_q;
                ci_last = inv_q ? cnt_q == 4'd0 : cnt_q == NR;
                if (ci_last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = inv_q ? cnt_q - 4'd1 : cnt_q + 4'd1;
                end
            end
            // held while start stays high so a level request cannot retrigger
            DONE: begin
                bus.done = 1'b1;
                if (!bus.start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef AES_CTRL_ABORT_EN
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
`endif
    end

    assign ci_inv = inv_q;
    assign round  = cnt_q;
endmodule
